// File: rtl/signal_detect_mc.sv
// rtl/signal_detect_mc.sv - multi-channel run-length detector with gap tolerance and runtime thresholds
module signal_detect_mc #(
  parameter int CH_NUM  = 4,
  parameter int CNT_W   = 10,
  parameter int MODE    = 0,
  parameter int GAP_TOL = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_clr,
  input  logic [CNT_W-1:0]        i_dn_th,
  input  logic [CNT_W-1:0]        i_up_th,
  input  logic [CH_NUM-1:0]       i_vld,
  input  logic [CH_NUM-1:0]       i_data,
  output logic [CH_NUM-1:0]       o_vld,
  output logic [CH_NUM-1:0]       o_data,
  output logic [CH_NUM*CNT_W-1:0] o_len,
  output logic [CH_NUM-1:0]       o_err,
  output logic                    o_cfg_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W:0]   ONE_X   = {{CNT_W{1'b0}}, 1'b1};
  localparam logic [3:0]       GAP_LIM = GAP_TOL[3:0];

  logic [CH_NUM-1:0]       run_act_q, run_act_d;
  logic [CH_NUM-1:0]       last_q, last_d;
  logic [CNT_W-1:0]        cnt_q [CH_NUM];
  logic [CNT_W-1:0]        cnt_d [CH_NUM];
  logic [3:0]              gap_q [CH_NUM];
  logic [3:0]              gap_d [CH_NUM];
  logic [CH_NUM-1:0]       vld_d, err_d, odata_d;
  logic [CH_NUM*CNT_W-1:0] olen_d;
  logic                    cfg_bad;

  always_comb begin
    cfg_bad   = (i_dn_th == '0) || (i_dn_th > i_up_th);
    run_act_d = run_act_q;
    last_d    = last_q;
    vld_d     = '0;
    err_d     = '0;
    odata_d   = o_data;
    olen_d    = o_len;
    for (int c = 0; c < CH_NUM; c++) begin
      cnt_d[c] = cnt_q[c];
      gap_d[c] = gap_q[c];
    end

    if (i_clr) begin
      run_act_d = '0;
      last_d    = '0;
      odata_d   = '0;
      olen_d    = '0;
      for (int c = 0; c < CH_NUM; c++) begin
        cnt_d[c] = '0;
        gap_d[c] = '0;
      end
    end else if (cfg_bad) begin
      run_act_d = '0;
      for (int c = 0; c < CH_NUM; c++) begin
        cnt_d[c] = '0;
        gap_d[c] = '0;
      end
    end else begin
      for (int c = 0; c < CH_NUM; c++) begin
        if (!i_vld[c]) begin
          // Idle cycles are tolerated up to GAP_TOL; the next one drops the run without a report.
          if (run_act_q[c]) begin
            if (gap_q[c] == GAP_LIM) begin
              run_act_d[c] = 1'b0;
              cnt_d[c]     = '0;
              gap_d[c]     = '0;
            end else begin
              gap_d[c] = gap_q[c] + 4'd1;
            end
          end
        end else begin
          gap_d[c] = '0;
          if (!run_act_q[c]) begin
            run_act_d[c] = 1'b1;
            last_d[c]    = i_data[c];
            cnt_d[c]     = ONE;
            if (MODE == 1 && i_dn_th == ONE) begin
              vld_d[c]                   = 1'b1;
              odata_d[c]                 = i_data[c];
              olen_d[c*CNT_W +: CNT_W]   = ONE;
              run_act_d[c]               = 1'b0;
              cnt_d[c]                   = '0;
            end
          end else if (i_data[c] == last_q[c]) begin
            if (MODE == 1 && ({1'b0, cnt_q[c]} + ONE_X) == {1'b0, i_dn_th}) begin
              vld_d[c]                   = 1'b1;
              odata_d[c]                 = i_data[c];
              olen_d[c*CNT_W +: CNT_W]   = i_dn_th;
              run_act_d[c]               = 1'b0;
              cnt_d[c]                   = '0;
            end else begin
              cnt_d[c] = (cnt_q[c] == CNT_MAX) ? CNT_MAX : cnt_q[c] + ONE;
            end
          end else begin
            // A value change closes the old run and this sample opens the next one.
            if (MODE == 0) begin
              if (cnt_q[c] >= i_dn_th && cnt_q[c] <= i_up_th) vld_d[c] = 1'b1;
              else                                            err_d[c] = 1'b1;
              odata_d[c]                 = last_q[c];
              olen_d[c*CNT_W +: CNT_W]   = cnt_q[c];
            end
            last_d[c] = i_data[c];
            cnt_d[c]  = ONE;
          end
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      run_act_q <= '0;
      last_q    <= '0;
      o_vld     <= '0;
      o_err     <= '0;
      o_data    <= '0;
      o_len     <= '0;
      o_cfg_err <= 1'b0;
      for (int c = 0; c < CH_NUM; c++) begin
        cnt_q[c] <= '0;
        gap_q[c] <= '0;
      end
    end else begin
      run_act_q <= run_act_d;
      last_q    <= last_d;
      o_vld     <= vld_d;
      o_err     <= err_d;
      o_data    <= odata_d;
      o_len     <= olen_d;
      o_cfg_err <= cfg_bad;
      for (int c = 0; c < CH_NUM; c++) begin
        cnt_q[c] <= cnt_d[c];
        gap_q[c] <= gap_d[c];
      end
    end
  end

endmodule

// File: tb/tb_signal_detect_mc.sv
// tb/tb_signal_detect_mc.sv - scoreboard bench for signal_detect_mc in PWM and OWT builds
module tb_signal_detect_mc;

  localparam int CH = 4;
  localparam int W  = 10;
  localparam logic [1:0] KV = 2'b01;
  localparam logic [1:0] KE = 2'b10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          p_clr, w_clr;
  logic [W-1:0]  p_dn, p_up, w_dn, w_up;
  logic [CH-1:0] p_vld, p_data, w_vld, w_data;
  logic [CH-1:0] p_ovld, p_odata, p_oerr, w_ovld, w_odata, w_oerr;
  logic [CH*W-1:0] p_olen, w_olen;
  logic          p_cfg, w_cfg;

  signal_detect_mc #(.CH_NUM(CH), .CNT_W(W), .MODE(0), .GAP_TOL(2)) dut_pwm (
    .i_clk(clk), .i_rst_n(rst_n), .i_clr(p_clr), .i_dn_th(p_dn), .i_up_th(p_up),
    .i_vld(p_vld), .i_data(p_data), .o_vld(p_ovld), .o_data(p_odata),
    .o_len(p_olen), .o_err(p_oerr), .o_cfg_err(p_cfg)
  );

  signal_detect_mc #(.CH_NUM(CH), .CNT_W(W), .MODE(1), .GAP_TOL(2)) dut_owt (
    .i_clk(clk), .i_rst_n(rst_n), .i_clr(w_clr), .i_dn_th(w_dn), .i_up_th(w_up),
    .i_vld(w_vld), .i_data(w_data), .o_vld(w_ovld), .o_data(w_odata),
    .o_len(w_olen), .o_err(w_oerr), .o_cfg_err(w_cfg)
  );

  typedef struct {
    int         cyc;
    int         ch;
    logic [1:0] kind;
    logic       data;
    logic [W-1:0] len;
  } exp_t;

  exp_t q_p[$];
  exp_t q_w[$];
  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s got=%0h want=%0h", tag, got, want);
  endtask

  task automatic take(input bit owt, input int c, input logic [1:0] k, input logic d, input logic [W-1:0] len);
    int idx = -1;
    exp_t e;
    string pfx;
    pfx = $sformatf("%s ch%0d", owt ? "owt" : "pwm", c);
    if (owt) begin
      for (int i = 0; i < q_w.size(); i++) if (q_w[i].ch == c) begin idx = i; break; end
    end else begin
      for (int i = 0; i < q_p.size(); i++) if (q_p[i].ch == c) begin idx = i; break; end
    end
    if (idx < 0) begin
      check({pfx, " unexpected pulse"}, 32'(k), 32'd0);
      return;
    end
    if (owt) begin e = q_w[idx]; q_w.delete(idx); end
    else     begin e = q_p[idx]; q_p.delete(idx); end
    check({pfx, " cycle"}, 32'(cyc), 32'(e.cyc));
    check({pfx, " kind"},  32'(k),   32'(e.kind));
    check({pfx, " data"},  32'(d),   32'(e.data));
    check({pfx, " len"},   32'(len), 32'(e.len));
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      for (int c = 0; c < CH; c++) begin
        if (p_ovld[c] | p_oerr[c]) take(1'b0, c, {p_oerr[c], p_ovld[c]}, p_odata[c], p_olen[c*W +: W]);
        if (w_ovld[c] | w_oerr[c]) take(1'b1, c, {w_oerr[c], w_ovld[c]}, w_odata[c], w_olen[c*W +: W]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic p_cyc(input logic [CH-1:0] v, input logic [CH-1:0] d);
    p_vld = v; p_data = d; tick();
  endtask

  task automatic w_cyc(input logic [CH-1:0] v, input logic [CH-1:0] d);
    w_vld = v; w_data = d; tick();
  endtask

  task automatic p_run(input int ch, input logic d, input int n);
    logic [CH-1:0] m;
    m = CH'(1) << ch;
    repeat (n) p_cyc(m, d ? m : '0);
  endtask

  task automatic w_run(input int ch, input logic d, input int n);
    logic [CH-1:0] m;
    m = CH'(1) << ch;
    repeat (n) w_cyc(m, d ? m : '0);
  endtask

  task automatic exp_p(input int ch, input logic [1:0] k, input logic d, input int len);
    exp_t e;
    e.cyc = cyc + 1; e.ch = ch; e.kind = k; e.data = d; e.len = W'(len);
    q_p.push_back(e);
  endtask

  task automatic exp_w(input int ch, input logic [1:0] k, input logic d, input int len);
    exp_t e;
    e.cyc = cyc + 1; e.ch = ch; e.kind = k; e.data = d; e.len = W'(len);
    q_w.push_back(e);
  endtask

  // Idle long enough to abort any open run, then require every expected report to have arrived.
  task automatic settle();
    p_vld = '0; w_vld = '0;
    repeat (4) tick();
    check("pending pwm reports", 32'(q_p.size()), 32'd0);
    check("pending owt reports", 32'(q_w.size()), 32'd0);
    q_p.delete();
    q_w.delete();
  endtask

  initial begin
    p_clr = 1'b0; w_clr = 1'b0;
    p_vld = '0; p_data = '0; w_vld = '0; w_data = '0;
    p_dn = 10'd4; p_up = 10'd8; w_dn = 10'd4; w_up = 10'd8;
    repeat (3) tick();
    check("reset o_vld",     32'(p_ovld), 32'd0);
    check("reset o_data",    32'(p_odata), 32'd0);
    check("reset o_len",     32'(p_olen), 32'd0);
    check("reset o_err",     32'(p_oerr), 32'd0);
    check("reset o_cfg_err", 32'(p_cfg), 32'd0);
    rst_n = 1'b1;
    tick();

    // PWM basic: 1x5 reported at the 0, new run counts from that 0
    p_run(0, 1'b1, 5);
    exp_p(0, KV, 1'b1, 5);
    p_run(0, 1'b0, 4);
    exp_p(0, KV, 1'b0, 4);
    p_run(0, 1'b1, 1);
    settle();
    check("hold o_len ch0", 32'(p_olen[W-1:0]), 32'd4);

    // synchronous clear mid-run, sample in the clear cycle ignored
    p_run(0, 1'b1, 3);
    p_clr = 1'b1;
    p_cyc(4'b0001, 4'b0001);
    p_clr = 1'b0;
    check("clear o_len", 32'(p_olen), 32'd0);
    p_run(0, 1'b1, 2);
    exp_p(0, KE, 1'b1, 2);
    p_run(0, 1'b0, 1);
    settle();

    // PWM out-of-range both sides on ch2
    p_run(2, 1'b1, 3);
    exp_p(2, KE, 1'b1, 3);
    p_run(2, 1'b0, 4);
    exp_p(2, KV, 1'b0, 4);
    p_run(2, 1'b1, 9);
    exp_p(2, KE, 1'b1, 9);
    p_run(2, 1'b0, 1);
    settle();

    // gap tolerance on ch3: two idles survive, three abort
    p_run(3, 1'b1, 2);
    p_cyc('0, '0); p_cyc('0, '0);
    p_run(3, 1'b1, 2);
    exp_p(3, KV, 1'b1, 4);
    p_run(3, 1'b0, 1);
    settle();
    p_run(3, 1'b1, 2);
    p_cyc('0, '0); p_cyc('0, '0); p_cyc('0, '0);
    p_run(3, 1'b1, 2);
    exp_p(3, KE, 1'b1, 2);
    p_run(3, 1'b0, 1);
    settle();

    // all channels end together, lengths 4..7
    for (int k = 0; k < 7; k++) begin
      logic [CH-1:0] v;
      v = '0;
      for (int c = 0; c < CH; c++) if (k >= 3 - c) v[c] = 1'b1;
      p_cyc(v, v);
    end
    for (int c = 0; c < CH; c++) exp_p(c, KV, 1'b1, 4 + c);
    p_cyc(4'hF, 4'h0);
    settle();

    // saturation of a long PWM run
    p_run(1, 1'b1, 1100);
    exp_p(1, KE, 1'b1, 1023);
    p_run(1, 1'b0, 1);
    settle();

    // configuration errors
    check("cfg_err idle", 32'(p_cfg), 32'd0);
    p_dn = 10'd0;
    p_cyc('0, '0);
    check("cfg_err dn=0", 32'(p_cfg), 32'd1);
    p_dn = 10'd4;
    p_cyc('0, '0);
    check("cfg_err cleared", 32'(p_cfg), 32'd0);
    p_run(0, 1'b1, 3);
    p_dn = 10'd9;
    p_run(0, 1'b1, 1);
    check("cfg_err dn>up", 32'(p_cfg), 32'd1);
    p_run(0, 1'b1, 4);
    p_run(0, 1'b0, 1);
    check("cfg_err held", 32'(p_cfg), 32'd1);
    p_dn = 10'd4;
    p_run(0, 1'b1, 1);
    check("cfg_err restored", 32'(p_cfg), 32'd0);
    p_run(0, 1'b1, 4);
    exp_p(0, KV, 1'b1, 5);
    p_run(0, 1'b0, 1);
    settle();

    // asynchronous reset mid-run discards the run
    p_run(0, 1'b1, 3);
    rst_n = 1'b0;
    #2;
    check("mid reset o_len",  32'(p_olen), 32'd0);
    check("mid reset o_data", 32'(p_odata), 32'd0);
    check("mid reset o_vld",  32'(p_ovld | p_oerr), 32'd0);
    tick();
    rst_n = 1'b1;
    p_run(0, 1'b0, 4);
    exp_p(0, KV, 1'b0, 4);
    p_run(0, 1'b1, 1);
    settle();

    // OWT: 0x10 reports after 4th and 8th samples
    for (int i = 1; i <= 10; i++) begin
      if (i == 4 || i == 8) exp_w(1, KV, 1'b0, 4);
      w_run(1, 1'b0, 1);
    end
    settle();

    // OWT: value change restarts silently
    w_run(1, 1'b0, 3);
    w_run(1, 1'b1, 3);
    exp_w(1, KV, 1'b1, 4);
    w_run(1, 1'b1, 1);
    settle();

    // OWT: dn=1 reports on every first sample
    w_dn = 10'd1;
    exp_w(2, KV, 1'b1, 1);
    w_run(2, 1'b1, 1);
    exp_w(2, KV, 1'b1, 1);
    w_run(2, 1'b1, 1);
    w_dn = 10'd4;
    settle();
    check("owt cfg_err", 32'(w_cfg), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
